// File: rtl/hram_arb_pkg.sv
// Shared types and constants for the HyperRAM two-client arbiter.
// Latency: n/a (types only). Backpressure: n/a.
package hram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic CLIENT_UART = 1'b0;
    localparam logic CLIENT_AUX  = 1'b1;

    localparam logic [5:0] RD_NUM_DWORDS = 6'h1;

endpackage

// File: rtl/hram_arbiter_rr_arb2.sv
// Two-way round-robin picker; a lone requester wins, a tie goes away from last_grant.
// Latency: combinational. Backpressure: none, the caller decides when to take the grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    assign gnt_valid = |req;
    assign gnt_id    = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/hram_arbiter.sv
// Round-robin arbiter/sequencer issuing single-dword transfers to hyper_xface; HRAM_ARB_TIMEOUT_EN adds a watchdog.
// Latency: ack the cycle after req is seen in IDLE, done the cycle after hr_busy is seen low.
// Backpressure: clients hold req until ack; only one transaction is in flight at a time.
module hram_arbiter
    import hram_arb_pkg::*;
#(
    parameter int BUSY_WAIT      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        c0_req,
    input  logic        c1_req,
    input  logic        c0_we,
    input  logic        c1_we,
    input  logic        c0_reg,
    input  logic        c1_reg,
    input  logic [31:0] c0_addr,
    input  logic [31:0] c1_addr,
    input  logic [31:0] c0_wr_d,
    input  logic [31:0] c1_wr_d,
    input  logic [3:0]  c0_be,
    input  logic [3:0]  c1_be,
    output logic        c0_ack,
    output logic        c1_ack,
    output logic        c0_done,
    output logic        c1_done,
    output logic        c0_rd_valid,
    output logic        c1_rd_valid,
    output logic [31:0] rd_d,
    output logic        err,
    output logic        hr_rd_req,
    output logic        hr_wr_req,
    output logic [31:0] hr_addr,
    output logic [31:0] hr_wr_d,
    output logic [3:0]  hr_be,
    output logic        hr_mem_or_reg,
    output logic [5:0]  hr_rd_num_dwords,
    input  logic        hr_busy,
    input  logic        hr_rd_rdy,
    input  logic [31:0] hr_rd_d
);

    localparam int BW_W = $clog2(BUSY_WAIT + 1);

    state_t          state;
    logic            last_grant;
    logic            cur_id;
    logic            cur_we;
    logic            got_data;
    logic [BW_W-1:0] busy_cnt;
    logic            gnt_valid;
    logic            gnt_id;
    logic            wd_fire;
    logic            err_q;

    logic            sel_we;
    logic            sel_reg;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wr_d;
    logic [3:0]      sel_be;

    rr_arb2 u_rr (
        .req        ({c1_req, c0_req}),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign sel_we   = gnt_id ? c1_we   : c0_we;
    assign sel_reg  = gnt_id ? c1_reg  : c0_reg;
    assign sel_addr = gnt_id ? c1_addr : c0_addr;
    assign sel_wr_d = gnt_id ? c1_wr_d : c0_wr_d;
    assign sel_be   = gnt_id ? c1_be   : c0_be;

    assign hr_rd_num_dwords = RD_NUM_DWORDS;
    assign err              = err_q;

`ifdef HRAM_ARB_TIMEOUT_EN
    localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WD_W   = (WD_RAW < 12) ? 12 : WD_RAW;

    logic [WD_W-1:0] wd_cnt;

    assign wd_fire = ((state == WAIT_ACK) || (state == WAIT_DONE)) &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rstn || state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT_ACK || state == WAIT_DONE) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            last_grant    <= CLIENT_AUX;
            cur_id        <= CLIENT_UART;
            cur_we        <= 1'b0;
            got_data      <= 1'b0;
            busy_cnt      <= '0;
            c0_ack        <= 1'b0;
            c1_ack        <= 1'b0;
            c0_done       <= 1'b0;
            c1_done       <= 1'b0;
            c0_rd_valid   <= 1'b0;
            c1_rd_valid   <= 1'b0;
            err_q         <= 1'b0;
            hr_rd_req     <= 1'b0;
            hr_wr_req     <= 1'b0;
            hr_addr       <= '0;
            hr_wr_d       <= '0;
            hr_be         <= 4'hF;
            hr_mem_or_reg <= 1'b0;
            rd_d          <= '0;
        end else begin
            c0_ack      <= 1'b0;
            c1_ack      <= 1'b0;
            c0_done     <= 1'b0;
            c1_done     <= 1'b0;
            c0_rd_valid <= 1'b0;
            c1_rd_valid <= 1'b0;
            err_q       <= 1'b0;
            hr_rd_req   <= 1'b0;
            hr_wr_req   <= 1'b0;

            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        hr_addr       <= sel_addr;
                        hr_wr_d       <= sel_wr_d;
                        hr_be         <= sel_be;
                        hr_mem_or_reg <= sel_reg;
                        cur_we        <= sel_we;
                        cur_id        <= gnt_id;
                        last_grant    <= gnt_id;
                        c0_ack        <= (gnt_id == CLIENT_UART);
                        c1_ack        <= (gnt_id == CLIENT_AUX);
                        // Request strobe is registered here so it is high exactly while in ISSUE.
                        hr_wr_req     <= sel_we;
                        hr_rd_req     <= ~sel_we;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    busy_cnt <= '0;
                    got_data <= 1'b0;
                    state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (wd_fire) begin
                        c0_done <= (cur_id == CLIENT_UART);
                        c1_done <= (cur_id == CLIENT_AUX);
                        err_q   <= 1'b1;
                        state   <= IDLE;
                    end else if (hr_busy || busy_cnt == BW_W'(BUSY_WAIT - 1)) begin
                        state <= WAIT_DONE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (wd_fire) begin
                        c0_done <= (cur_id == CLIENT_UART);
                        c1_done <= (cur_id == CLIENT_AUX);
                        err_q   <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        if (!cur_we && hr_rd_rdy) begin
                            rd_d        <= hr_rd_d;
                            c0_rd_valid <= (cur_id == CLIENT_UART);
                            c1_rd_valid <= (cur_id == CLIENT_AUX);
                            got_data    <= 1'b1;
                        end
                        // Data arriving in the same cycle busy drops still completes now.
                        if (!hr_busy && (cur_we || got_data || hr_rd_rdy)) begin
                            c0_done <= (cur_id == CLIENT_UART);
                            c1_done <= (cur_id == CLIENT_AUX);
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hram_arbiter.sv
// Randomized bench for hram_arbiter with a reactive hyper_xface model and a round-robin/memory reference.
module tb_hram_arbiter;

    localparam int BW = 8;
    localparam int TO = 64;

    logic        clk, rstn;
    logic        c0_req, c1_req, c0_we, c1_we, c0_reg, c1_reg;
    logic [31:0] c0_addr, c1_addr, c0_wr_d, c1_wr_d;
    logic [3:0]  c0_be, c1_be;
    logic        c0_ack, c1_ack, c0_done, c1_done, c0_rd_valid, c1_rd_valid;
    logic [31:0] rd_d;
    logic        err, hr_rd_req, hr_wr_req;
    logic [31:0] hr_addr, hr_wr_d;
    logic [3:0]  hr_be;
    logic        hr_mem_or_reg;
    logic [5:0]  hr_rd_num_dwords;
    logic        hr_busy, hr_rd_rdy;
    logic [31:0] hr_rd_d;

    hram_arbiter #(.BUSY_WAIT(BW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn),
        .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
        .c0_reg(c0_reg), .c1_reg(c1_reg), .c0_addr(c0_addr), .c1_addr(c1_addr),
        .c0_wr_d(c0_wr_d), .c1_wr_d(c1_wr_d), .c0_be(c0_be), .c1_be(c1_be),
        .c0_ack(c0_ack), .c1_ack(c1_ack), .c0_done(c0_done), .c1_done(c1_done),
        .c0_rd_valid(c0_rd_valid), .c1_rd_valid(c1_rd_valid), .rd_d(rd_d), .err(err),
        .hr_rd_req(hr_rd_req), .hr_wr_req(hr_wr_req), .hr_addr(hr_addr), .hr_wr_d(hr_wr_d),
        .hr_be(hr_be), .hr_mem_or_reg(hr_mem_or_reg), .hr_rd_num_dwords(hr_rd_num_dwords),
        .hr_busy(hr_busy), .hr_rd_rdy(hr_rd_rdy), .hr_rd_d(hr_rd_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference state
    logic        exp_last;
    logic [31:0] ref_mem [logic [32:0]];
    logic        s_we [2];
    logic        s_reg [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_wd [2];
    logic [3:0]  s_be [2];
    logic [31:0] s_exp [2];

    // hyper_xface model state
    int          m_mode = 0;   // 0 normal, 1 never busy, 2 busy stuck
    int          m_len  = 0;   // 0 = random busy length
    bit          m_kill = 1'b0;
    int          m_phase = 0;
    int          m_cnt = 0;
    bit          m_we, m_coinc;
    logic [32:0] m_key;
    logic [31:0] hmem [logic [32:0]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_slot(input int c);
        s_we[c]   = 1'($urandom_range(0, 1));
        s_reg[c]  = ($urandom_range(0, 3) == 0);
        s_addr[c] = 32'($urandom_range(0, 7)) << 2;
        s_wd[c]   = $urandom;
        s_be[c]   = 4'($urandom_range(1, 15));
    endtask

    task automatic drive(input int c, input bit on);
        logic        w, r;
        logic [31:0] a, d;
        logic [3:0]  b;
        w = on ? s_we[c]   : 1'($urandom_range(0, 1));
        r = on ? s_reg[c]  : 1'($urandom_range(0, 1));
        a = on ? s_addr[c] : $urandom;
        d = on ? s_wd[c]   : $urandom;
        b = on ? s_be[c]   : 4'($urandom_range(0, 15));
        if (c == 0) begin
            c0_req = on; c0_we = w; c0_reg = r; c0_addr = a; c0_wr_d = d; c0_be = b;
        end else begin
            c1_req = on; c1_we = w; c1_reg = r; c1_addr = a; c1_wr_d = d; c1_be = b;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_acks",   32'({c0_ack, c1_ack}), 0);
        chk("rst_dones",  32'({c0_done, c1_done}), 0);
        chk("rst_rdv",    32'({c0_rd_valid, c1_rd_valid}), 0);
        chk("rst_reqs",   32'({hr_rd_req, hr_wr_req}), 0);
        chk("rst_err",    32'(err), 0);
        chk("rst_rd_d",   rd_d, 0);
        chk("rst_addr",   hr_addr, 0);
        chk("rst_wr_d",   hr_wr_d, 0);
        chk("rst_be",     32'(hr_be), 32'hF);
        chk("rst_mor",    32'(hr_mem_or_reg), 0);
        chk("rst_ndw",    32'(hr_rd_num_dwords), 1);
    endtask

    task automatic do_reset();
        m_kill = 1'b1;
        m_mode = 0;
        rstn   = 1'b0;
        step();
        chk_reset_outputs();
        rstn     = 1'b1;
        exp_last = 1'b1;
    endtask

    // Runs n0 transactions from client 0 and n1 from client 1, re-requesting right after each done.
    task automatic run(input int n0, input int n1);
        int  left [2];
        bit  pend [2];
        int  active, pulses, rdv, fall_cyc, req_cyc, start_cyc, budget, ai, c, leftover;
        bit  busy_seen, prev_busy, done_prev, first_ack;
        logic a [2];
        logic d [2];
        logic v [2];
        left[0] = n0; left[1] = n1;
        active = -1; pulses = 0; rdv = 0; fall_cyc = -1; req_cyc = -1;
        busy_seen = 0; prev_busy = hr_busy; done_prev = 0; first_ack = 1;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0;
            if (left[k] > 0) begin pend[k] = 1; left[k]--; drive(k, 1); end
        end
        start_cyc = cyc;
        budget = 100 * (n0 + n1) + 50;
        while ((pend[0] || pend[1] || active >= 0) && budget > 0) begin
            step();
            budget--;
            a[0] = c0_ack; a[1] = c1_ack;
            d[0] = c0_done; d[1] = c1_done;
            v[0] = c0_rd_valid; v[1] = c1_rd_valid;
            if (done_prev && (pend[0] || pend[1])) chk("b2b_ack", 32'(a[0] | a[1]), 1);
            done_prev = 0;
            if (a[0] || a[1]) begin
                int g, e;
                g = a[1] ? 1 : 0;
                e = (pend[0] && pend[1]) ? (exp_last ? 0 : 1) : (pend[1] ? 1 : 0);
                chk("grant_id", g, e);
                chk("single_ack", 32'(a[0] & a[1]), 0);
                chk("ack_when_idle", active, -1);
                if (first_ack) chk("ack_latency", cyc - start_cyc, 1);
                first_ack = 0;
                active = g; exp_last = 1'(g); pend[g] = 0;
                pulses = 0; rdv = 0; busy_seen = 0; req_cyc = -1;
                if (s_we[g])
                    ref_mem[{s_reg[g], s_addr[g]}] = merge(ref_mem.exists({s_reg[g], s_addr[g]}) ?
                        ref_mem[{s_reg[g], s_addr[g]}] : 32'h0, s_wd[g], s_be[g]);
                else
                    s_exp[g] = ref_mem.exists({s_reg[g], s_addr[g]}) ? ref_mem[{s_reg[g], s_addr[g]}] : 32'h0;
                drive(g, 0);
            end
            ai = (active < 0) ? 0 : active;
            if (hr_wr_req || hr_rd_req) begin
                pulses++;
                req_cyc = cyc;
                chk("req_type", 32'({hr_wr_req, hr_rd_req}), (active < 0) ? 0 : (s_we[ai] ? 2 : 1));
            end
            if (active >= 0) begin
                chk("hold_addr", hr_addr, s_addr[ai]);
                chk("hold_wr_d", hr_wr_d, s_wd[ai]);
                chk("hold_be",   32'(hr_be), 32'(s_be[ai]));
                chk("hold_mor",  32'(hr_mem_or_reg), 32'(s_reg[ai]));
                chk("num_dw",    32'(hr_rd_num_dwords), 1);
                if (hr_busy) busy_seen = 1;
                else if (prev_busy) fall_cyc = cyc;
            end
            if (v[0] || v[1]) begin
                chk("rdv_client", v[1] ? 1 : 0, active);
                chk("rdv_on_read", 32'(s_we[ai]), 0);
                chk("rd_d", rd_d, s_exp[ai]);
                rdv++;
            end
            if (d[0] || d[1]) begin
                chk("done_client", d[1] ? 1 : 0, active);
                chk("done_err", 32'(err), 0);
                chk("req_pulses", pulses, 1);
                chk("rdv_count", rdv, s_we[ai] ? 0 : 1);
                if (busy_seen) chk("done_after_busy_fall", cyc, fall_cyc);
                else chk("wait_ack_exit", 32'((cyc - req_cyc >= BW + 1) && (cyc - req_cyc <= BW + 3)), 1);
                done_prev = 1;
                c = ai;
                active = -1;
                if (left[c] > 0) begin left[c]--; rand_slot(c); drive(c, 1); pend[c] = 1; end
            end
            prev_busy = hr_busy;
        end
        leftover = int'(pend[0]) + int'(pend[1]) + ((active >= 0) ? 1 : 0);
        chk("run_complete", leftover, 0);
    endtask

    task automatic wait_ack(input int c, output bit got);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if ((c == 0) ? c0_ack : c1_ack) got = 1;
        end
        chk("custom_ack", 32'(got), 1);
        exp_last = 1'(c);
        drive(c, 0);
    endtask

    // hyper_xface model: reacts on the falling edge so its outputs are stable at the DUT edge.
    initial begin
        hr_busy = 1'b0; hr_rd_rdy = 1'b0; hr_rd_d = '0;
        forever begin
            @(negedge clk);
            hr_rd_rdy = 1'b0;
            if (m_kill) begin
                m_kill = 1'b0; m_phase = 0; hr_busy = 1'b0;
            end else begin
                case (m_phase)
                    0: if (hr_wr_req || hr_rd_req) begin
                        m_we  = hr_wr_req;
                        m_key = {hr_mem_or_reg, hr_addr};
                        if (hr_wr_req)
                            hmem[m_key] = merge(hmem.exists(m_key) ? hmem[m_key] : 32'h0, hr_wr_d, hr_be);
                        m_coinc = 1'($urandom_range(0, 1));
                        if (m_mode == 2) begin hr_busy = 1'b1; m_phase = 3; end
                        else if (m_mode == 0) begin m_cnt = int'($urandom_range(0, 3)); m_phase = 1; end
                    end else if ($urandom_range(0, 7) == 0) begin
                        hr_rd_rdy = 1'b1; hr_rd_d = $urandom;
                    end
                    1: if (m_cnt == 0) begin
                        hr_busy = 1'b1;
                        m_cnt = (m_len != 0) ? m_len : int'($urandom_range(2, 12));
                        m_phase = 2;
                    end else begin
                        m_cnt--;
                        if ($urandom_range(0, 1) == 1) begin hr_rd_rdy = 1'b1; hr_rd_d = $urandom; end
                    end
                    2: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            hr_busy = 1'b0; m_phase = 0;
                            if (!m_we && m_coinc) begin
                                hr_rd_rdy = 1'b1; hr_rd_d = hmem.exists(m_key) ? hmem[m_key] : 32'h0;
                            end
                        end else if (m_cnt == 1 && !m_we && !m_coinc) begin
                            hr_rd_rdy = 1'b1; hr_rd_d = hmem.exists(m_key) ? hmem[m_key] : 32'h0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        bit          got, seen_done, seen_err, err_at_done, seen_rdv, seen_a0;
        int          req_cyc, done_cyc;
        logic [31:0] rd_before;

        rstn = 1'b0;
        exp_last = 1'b1;
        for (int k = 0; k < 2; k++) begin rand_slot(k); drive(k, 0); end
        c0_req = 1'b0; c1_req = 1'b0;
        step(); step();
        chk_reset_outputs();
        rstn = 1'b1;
        step();

        // c0 write 0x10 with a 20-cycle busy window
        s_we[0] = 1; s_reg[0] = 0; s_addr[0] = 32'h10; s_wd[0] = 32'hDEADBEEF; s_be[0] = 4'hF;
        m_len = 20;
        run(1, 0);
        m_len = 0;

        // c1 reads it back
        s_we[1] = 0; s_reg[1] = 0; s_addr[1] = 32'h10; s_wd[1] = $urandom; s_be[1] = 4'hF;
        run(0, 1);

        // simultaneous requests straight after reset, then sustained contention
        do_reset();
        rand_slot(0); rand_slot(1);
        run(1, 1);
        rand_slot(0); rand_slot(1);
        run(3, 3);

        // interface never raises busy on a write
        m_mode = 1;
        rand_slot(0); s_we[0] = 1;
        run(1, 0);
        m_mode = 0;

        // reset in WAIT_DONE abandons the read silently
        m_mode = 2;
        rand_slot(0); s_we[0] = 0;
        drive(0, 1);
        wait_ack(0, got);
        repeat (15) step();
        do_reset();
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (c0_done || c1_done) seen_done = 1;
        end
        chk("no_done_after_reset", 32'(seen_done), 0);
        rand_slot(1);
        run(0, 1);

        // busy stuck high on a read
        m_mode = 2;
        rand_slot(1); s_we[1] = 0;
        rd_before = rd_d;
        drive(1, 1);
        req_cyc = cyc;
        wait_ack(1, got);
`ifndef HRAM_ARB_TIMEOUT_EN
        rand_slot(0);
        drive(0, 1);
`endif
        seen_done = 0; seen_err = 0; err_at_done = 0; seen_rdv = 0; seen_a0 = 0; done_cyc = 0;
        for (int k = 0; k < 3 * TO && !seen_done; k++) begin
            step();
            if (hr_rd_req) req_cyc = cyc;
            if (err) seen_err = 1;
            if (c0_rd_valid || c1_rd_valid) seen_rdv = 1;
            if (c0_ack) seen_a0 = 1;
            if (c1_done) begin seen_done = 1; err_at_done = err; done_cyc = cyc; end
        end
`ifdef HRAM_ARB_TIMEOUT_EN
        chk("to_done", 32'(seen_done), 1);
        chk("to_err_with_done", 32'(err_at_done), 1);
        chk("to_cycle", 32'((done_cyc - req_cyc >= TO - 1) && (done_cyc - req_cyc <= TO + 3)), 1);
        chk("to_rd_d_kept", rd_d, rd_before);
        chk("to_no_rdv", 32'(seen_rdv), 0);
        step();
        chk("to_err_one_cycle", 32'(err), 0);
`else
        chk("stuck_no_done", 32'(seen_done), 0);
        chk("stuck_no_err", 32'(seen_err), 0);
        chk("stuck_no_grant", 32'(seen_a0), 0);
        drive(0, 0);
`endif
        do_reset();
        step();

        // random mix
        for (int r = 0; r < 30; r++) begin
            int n0, n1;
            n0 = int'($urandom_range(0, 2));
            n1 = int'($urandom_range(0, 2));
            if (n0 + n1 == 0) n0 = 1;
            rand_slot(0); rand_slot(1);
            run(n0, n1);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hram_arbiter.md
Name: hram_arbiter

Overview:
- Two-client round-robin arbiter and sequencer in front of the hyper_xface user port.
- Client 0 is the UART command engine; client 1 is a second master, e.g. a pattern tester.
- Latches one single-dword read or write per grant and pulses hyper_xface rd_req/wr_req.
- Tracks busy/rd_rdy to completion, then returns read data and a done strobe to the granted client.

Parameters:
BUSY_WAIT, 8, max cycles after issue to see hr_busy rise before moving to WAIT_DONE anyway
TIMEOUT_CYCLES, 4096, watchdog limit per transaction (only with optional feature)

Ports:
clk  in  1  system clock (hram_clk domain)
rstn  in  1  synchronous active-low reset
c0_req, c1_req  in  1  request; hold until matching ack
c0_we, c1_we  in  1  1 = write, 0 = read
c0_reg, c1_reg  in  1  register space access (drives mem_or_reg)
c0_addr, c1_addr  in  32  address
c0_wr_d, c1_wr_d  in  32  write data
c0_be, c1_be  in  4  write byte enables
c0_ack, c1_ack  out  1  one-cycle accept strobe
c0_done, c1_done  out  1  one-cycle completion strobe
c0_rd_valid, c1_rd_valid  out  1  one-cycle read-data strobe
rd_d  out  32  captured read data, shared, valid with cN_rd_valid
err  out  1  one-cycle timeout flag, coincident with done
hr_rd_req, hr_wr_req  out  1  to hyper_xface, one-cycle pulse
hr_addr  out  32  to hyper_xface
hr_wr_d  out  32  to hyper_xface
hr_be  out  4  to hyper_xface
hr_mem_or_reg  out  1  to hyper_xface
hr_rd_num_dwords  out  6  constant 6'h1
hr_busy  in  1  from hyper_xface
hr_rd_rdy  in  1  from hyper_xface
hr_rd_d  in  32  from hyper_xface

Behaviour:
- Reset (rstn=0 at posedge clk):
  - State IDLE.
  - All strobes and hr_*_req = 0.
  - hr_addr, hr_wr_d, rd_d = 0; hr_be = 4'hF; hr_mem_or_reg = 0.
  - last_grant = 1, so client 0 wins first contention.
  - Reset mid-transaction abandons it silently: no done for that transaction.
- IDLE:
  - Requesters are sampled each cycle.
  - Single requester is granted.
  - Both requesting: grant goes to the client != last_grant.
  - On grant, in the same cycle:
    - Latch we/reg/addr/wr_d/be into the hr_* registers.
    - Pulse cN_ack.
    - Update last_grant.
    - Go to ISSUE.
- ISSUE:
  - Assert hr_wr_req (we=1) or hr_rd_req (we=0) for exactly one cycle.
  - Go to WAIT_ACK; clear cycle counter.
- WAIT_ACK:
  - hr_busy=1 -> WAIT_DONE.
  - Counter reaches BUSY_WAIT -> WAIT_DONE (absorbs interface delay).
- WAIT_DONE:
  - Read: on hr_rd_rdy, capture hr_rd_d into rd_d, pulse cN_rd_valid, set got_data.
  - Completes when hr_busy=0 and (write or got_data).
  - hr_rd_rdy and hr_busy falling in the same cycle: capture and complete in that cycle.
  - Completion pulses cN_done, then go to IDLE.
- Stability: hr_addr/hr_wr_d/hr_be/hr_mem_or_reg are held constant from ISSUE until return to IDLE.
- Latency:
  - Earliest accept is the cycle req is seen in IDLE.
  - A new grant is possible the cycle after done (back-to-back).
- Deassertion: client dropping req before ack withdraws the request; no ack is issued.
- Ignored input: hr_rd_rdy outside WAIT_DONE is ignored.

Optional Feature:
- Macro HRAM_ARB_TIMEOUT_EN.
- Defined:
  - 12-bit+ watchdog counts in WAIT_ACK and WAIT_DONE.
  - At TIMEOUT_CYCLES: pulse cN_done and err together, leave rd_d unchanged, return to IDLE.
- Undefined:
  - No watchdog; err tied 0.
  - WAIT_DONE waits indefinitely.

Decomposition:
- Package hram_arb_pkg holds:
  - State encoding localparams: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - Client id constants CLIENT_UART=0, CLIENT_AUX=1.
  - Constant RD_NUM_DWORDS=6'h1.
- Sub-module rr_arb2: combinational two-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_valid, gnt_id.
  - The FSM remains in hram_arbiter.

Test Plan:
1. c0 write addr=0x10, wr_d=0xDEADBEEF, be=4'hF -> c0_ack the next cycle, hr_wr_req single pulse with hr_addr=0x10; model busy high 20 cycles -> c0_done one cycle after busy falls.
2. c1 read addr=0x10; model returns hr_rd_d=0xDEADBEEF on hr_rd_rdy -> c1_rd_valid with rd_d=0xDEADBEEF, then c1_done; c0 strobes stay 0.
3. c0 and c1 request in the same cycle after reset -> c0 granted first, c1 granted the cycle after c0_done; repeat with both held -> strict alternation over 6 grants.
4. Model never raises busy on a write -> WAIT_ACK exits after 8 cycles; done once busy=0.
5. rstn low during WAIT_DONE -> all outputs at reset values next cycle, no done; a fresh c1 request completes normally.
6. With HRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, busy stuck high -> done and err pulse together at cycle 64; without the macro, err stays 0 and the FSM stays in WAIT_DONE.
